ifetch_buf: RTL

IFETCH_BUF -- requirements
Module: ifetch_buf

---
 rtl/ifetch_buf_if.sv | 31 +++
 rtl/ifetch_buf.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ifetch_buf_if.sv
// Fetch-side bundle: redirect control, instruction-memory request/response,
// and the decoded-instruction handshake toward decode.
interface ifetch_buf_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    input  redirect, redirect_pc,
    output imem_req, imem_addr,
    input  imem_rdy, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect, redirect_pc,
    input  imem_req, imem_addr,
    output imem_rdy, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/ifetch_buf.sv
// Instruction prefetch buffer: credit-limited in-order fetch, registered queue,
// redirect flush with stale-response discard. IFETCH_STATS_EN adds perf_stall_cnt.
module ifetch_buf #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  ifetch_buf_if.master bus
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]  perf_stall_cnt
`endif
);
  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUM_W  = CNT_W + 1;

  logic [DATA_W-1:0] fetch_pc;
  logic [DATA_W-1:0] resp_pc;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W-1:0]  q_count_nxt;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_nxt;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W-1:0]  discard_nxt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] q_word [DEPTH];
  logic [DATA_W-1:0] q_pc   [DEPTH];

  logic credit_ok;
  logic req;
  logic accept;
  logic resp_hit;
  logic resp_drop;
  logic resp_take;
  logic push;
  logic head_valid;
  logic pop;

  // Credits cover both queued words and in-flight requests, so the queue can never overflow.
  always_comb begin
    credit_ok  = (SUM_W'(q_count) + SUM_W'(outstanding)) < SUM_W'(DEPTH);
    req        = rst_n && credit_ok && (discard == '0) && !bus.redirect;
    accept     = req && bus.imem_rdy;
    resp_hit   = bus.imem_rvalid && ((discard != '0) || (outstanding != '0));
    resp_drop  = bus.imem_rvalid && (discard != '0);
    resp_take  = bus.imem_rvalid && (discard == '0) && (outstanding != '0);
    push       = resp_take && !bus.redirect;
    head_valid = (q_count != '0) && !bus.redirect;
    pop        = head_valid && bus.instr_ready;
  end

  always_comb begin
    q_count_nxt     = q_count;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    if (bus.redirect) begin
      // Everything still in flight becomes stale; a response landing now is dropped on the spot.
      q_count_nxt     = '0;
      outstanding_nxt = '0;
      discard_nxt     = discard + outstanding - CNT_W'(resp_hit);
    end else begin
      case ({push, pop})
        2'b10:   q_count_nxt = q_count + CNT_W'(1);
        2'b01:   q_count_nxt = q_count - CNT_W'(1);
        default: q_count_nxt = q_count;
      endcase
      case ({accept, resp_take})
        2'b10:   outstanding_nxt = outstanding + CNT_W'(1);
        2'b01:   outstanding_nxt = outstanding - CNT_W'(1);
        default: outstanding_nxt = outstanding;
      endcase
      if (resp_drop) begin
        discard_nxt = discard - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      q_count     <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      q_count     <= q_count_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc;
        resp_pc  <= bus.redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // Queue storage carries no reset; occupancy alone qualifies the head.
  always_ff @(posedge clk) begin
    if (push) begin
      q_word[wr_ptr] <= bus.imem_rdata;
      q_pc[wr_ptr]   <= resp_pc;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = (q_count != '0) ? q_word[rd_ptr] : '0;
  assign bus.instr_pc    = (q_count != '0) ? q_pc[rd_ptr]   : resp_pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (q_count == CNT_W'(DEPTH))));

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (SUM_W'(q_count) + SUM_W'(outstanding)) <= SUM_W'(DEPTH));

`ifdef IFETCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Decode wanted a word but none was presented, redirect cycles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
    end else if (bus.instr_ready && !head_valid) begin
      perf_stall_cnt <= sat_inc(perf_stall_cnt);
    end
  end
`endif

endmodule
